pcie_pio_irq_regs: RTL and testbench

- Parametrised PIO register and interrupt controller between pcie_rx (PIO strobes) and pcie_tx (read completions) in the PCIe top level.
- Supports N_IRQ latched interrupt sources with per-source enable, write-1-to-clear, race-free read-to-clear, and MSI coalescing with a programmable holdoff.
- Keeps wrapping traffic counters and drives a fixed 2-cycle read-completion pipeline.
- Registers at addresses 16 and above come from an external register file through ext_read_data.

---
 rtl/pcie_pio_irq_regs.sv | 202 ++++++++++++++++++++
 tb/tb_pcie_pio_irq_regs.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_pio_irq_regs.sv
// PIO register block and MSI interrupt controller sitting between pcie_rx and pcie_tx.
// Latched IRQ sources, wrapping traffic counters and a fixed 2-cycle read completion pipeline.
module pcie_pio_irq_regs #(
    parameter int unsigned N_IRQ   = 4,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned COUNT_W = 16,
    parameter logic [7:0]  VERSION = 8'd2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pio_write_valid,
    input  logic              pio_read_valid,
    input  logic [ADDR_W-1:0] pio_address,
    input  logic [63:0]       pio_write_data,
    input  logic [23:0]       rid_tag,
    input  logic              completion_valid,
    input  logic [N_IRQ-1:0]  irq,
    input  logic [63:0]       ext_read_data,
    output logic              cfg_interrupt,
    input  logic              cfg_interrupt_rdy,
    output logic              read_completion_valid,
    output logic [23:0]       read_completion_rid_tag,
    output logic [3:0]        read_completion_lower_addr,
    output logic [63:0]       read_completion_data
);

    typedef enum logic [1:0] {StIdle, StReq, StHold} msi_state_e;

    logic [N_IRQ-1:0]   enable_q, latch_q, clr_mask;
    logic [15:0]        holdoff_q, hold_cnt_q;
    logic [COUNT_W-1:0] read_count_q, write_count_q, cpld_count_q;
    logic [31:0]        msi_count_q;
    msi_state_e         state_q;
    logic               pend_q, cfg_interrupt_q;

    logic               is_ext, wr_sel;
    logic [3:0]         reg_addr;
    logic               wr_enable, wr_irq_clr, wr_cnt_clr, wr_holdoff, rd_latch_clr;
    logic               trigger;
    logic [63:0]        reg_rdata;

    logic               s1_valid_q, s1_ext_q;
    logic [23:0]        s1_rid_q;
    logic [3:0]         s1_addr_q;
    logic [63:0]        s1_data_q;
    logic               rc_valid_q;
    logic [23:0]        rc_rid_q;
    logic [3:0]         rc_addr_q;
    logic [63:0]        rc_data_q;

    logic               unused_wdata;
    assign unused_wdata = ^pio_write_data;

    assign is_ext       = |pio_address[ADDR_W-1:4];
    assign reg_addr     = pio_address[3:0];
    assign wr_sel       = pio_write_valid && !is_ext;
    assign wr_enable    = wr_sel && (reg_addr == 4'd0);
    assign wr_irq_clr   = wr_sel && (reg_addr == 4'd1);
    assign wr_cnt_clr   = wr_sel && (reg_addr == 4'd2);
    assign wr_holdoff   = wr_sel && (reg_addr == 4'd4);
    assign rd_latch_clr = pio_read_valid && !is_ext && (reg_addr == 4'd0);

    // A new enable that uncovers already-latched events must also raise an MSI.
    assign trigger = (|(irq & enable_q)) ||
                     (wr_enable && (|(pio_write_data[N_IRQ-1:0] & latch_q)));

    always_comb begin
        clr_mask = '0;
        if (rd_latch_clr) begin
            clr_mask = '1;
        end else if (wr_irq_clr) begin
            clr_mask = pio_write_data[N_IRQ-1:0];
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            4'd0: begin
                reg_rdata[63:56]      = VERSION;
                reg_rdata[N_IRQ-1:0]  = latch_q;
            end
            4'd1: reg_rdata[N_IRQ-1:0]     = latch_q & enable_q;
            4'd2: reg_rdata[3*COUNT_W-1:0] = {cpld_count_q, write_count_q, read_count_q};
            4'd3: reg_rdata[31:0]          = msi_count_q;
            4'd4: reg_rdata[15:0]          = holdoff_q;
            default: ;
        endcase
    end

    // Same-cycle irq is OR-ed after the clear so no event is lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            enable_q  <= '0;
            latch_q   <= '0;
            holdoff_q <= '0;
        end else begin
            latch_q <= (latch_q & ~clr_mask) | irq;
            if (wr_enable) enable_q <= pio_write_data[N_IRQ-1:0];
            if (wr_holdoff) holdoff_q <= pio_write_data[15:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || wr_cnt_clr) begin
            read_count_q  <= '0;
            write_count_q <= '0;
            cpld_count_q  <= '0;
        end else begin
            if (pio_read_valid) read_count_q <= read_count_q + COUNT_W'(1);
            if (pio_write_valid) write_count_q <= write_count_q + COUNT_W'(1);
            if (completion_valid) cpld_count_q <= cpld_count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            cfg_interrupt_q <= 1'b0;
            pend_q          <= 1'b0;
            hold_cnt_q      <= '0;
            msi_count_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (trigger) begin
                        state_q         <= StReq;
                        cfg_interrupt_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (cfg_interrupt_rdy) begin
                        msi_count_q <= msi_count_q + 32'd1;
                        if (holdoff_q == 16'd0) begin
                            state_q         <= trigger ? StReq : StIdle;
                            cfg_interrupt_q <= trigger;
                        end else begin
                            state_q         <= StHold;
                            cfg_interrupt_q <= 1'b0;
                            hold_cnt_q      <= holdoff_q;
                            pend_q          <= trigger;
                        end
                    end
                end
                StHold: begin
                    if (hold_cnt_q <= 16'd1) begin
                        pend_q <= 1'b0;
                        if (pend_q || trigger) begin
                            state_q         <= StReq;
                            cfg_interrupt_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 16'd1;
                        pend_q     <= pend_q || trigger;
                    end
                end
                default: begin
                    state_q         <= StIdle;
                    cfg_interrupt_q <= 1'b0;
                end
            endcase
        end
    end

    // Internal data is captured at the strobe so the read-clear cannot race it.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_ext_q   <= 1'b0;
            s1_rid_q   <= '0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            rc_valid_q <= 1'b0;
            rc_rid_q   <= '0;
            rc_addr_q  <= '0;
            rc_data_q  <= '0;
        end else begin
            s1_valid_q <= pio_read_valid;
            if (pio_read_valid) begin
                s1_ext_q  <= is_ext;
                s1_rid_q  <= rid_tag;
                s1_addr_q <= reg_addr;
                s1_data_q <= reg_rdata;
            end
            rc_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rc_rid_q  <= s1_rid_q;
                rc_addr_q <= s1_addr_q;
                rc_data_q <= s1_ext_q ? ext_read_data : s1_data_q;
            end
        end
    end

    assign cfg_interrupt              = cfg_interrupt_q;
    assign read_completion_valid      = rc_valid_q;
    assign read_completion_rid_tag    = rc_rid_q;
    assign read_completion_lower_addr = rc_addr_q;
    assign read_completion_data       = rc_data_q;

endmodule

// File: tb/tb_pcie_pio_irq_regs.sv
// Bench for pcie_pio_irq_regs: a register vector table, directed MSI/pipeline corner
// sequences, and randomized traffic scored against a behavioural register-map model.
module tb_pcie_pio_irq_regs;
    localparam int unsigned N_IRQ   = 4;
    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned COUNT_W = 16;
    localparam logic [63:0] VER_WORD = 64'h0200_0000_0000_0000;
    localparam int          N_RAND  = 3000;

    logic              clock = 1'b0;
    logic              reset;
    logic              pio_write_valid, pio_read_valid;
    logic [ADDR_W-1:0] pio_address;
    logic [63:0]       pio_write_data;
    logic [23:0]       rid_tag;
    logic              completion_valid;
    logic [N_IRQ-1:0]  irq;
    logic [63:0]       ext_read_data;
    logic              cfg_interrupt, cfg_interrupt_rdy;
    logic              read_completion_valid;
    logic [23:0]       read_completion_rid_tag;
    logic [3:0]        read_completion_lower_addr;
    logic [63:0]       read_completion_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pcie_pio_irq_regs #(
        .N_IRQ  (N_IRQ),
        .ADDR_W (ADDR_W),
        .COUNT_W(COUNT_W),
        .VERSION(8'd2)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .pio_write_valid           (pio_write_valid),
        .pio_read_valid            (pio_read_valid),
        .pio_address               (pio_address),
        .pio_write_data            (pio_write_data),
        .rid_tag                   (rid_tag),
        .completion_valid          (completion_valid),
        .irq                       (irq),
        .ext_read_data             (ext_read_data),
        .cfg_interrupt             (cfg_interrupt),
        .cfg_interrupt_rdy         (cfg_interrupt_rdy),
        .read_completion_valid     (read_completion_valid),
        .read_completion_rid_tag   (read_completion_rid_tag),
        .read_completion_lower_addr(read_completion_lower_addr),
        .read_completion_data      (read_completion_data)
    );

    typedef struct {
        int          kind;   // 0 irq pulse, 1 write, 2 read
        int          addr;
        logic [63:0] wdata;
        logic [3:0]  irqv;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        int          due;
        logic [23:0] tag;
        logic [3:0]  la;
        logic [63:0] data;
    } exp_t;

    vec_t vecs[20];
    exp_t expq[$];
    exp_t e;
    int   acc[$];

    // Behavioural model state
    logic [3:0]  m_latch, m_en, clr;
    int unsigned m_hold, m_cr, m_cw, m_cc;
    logic [31:0] m_msi;
    logic [63:0] d, wdata;
    logic [23:0] rtag;
    int          op, sel, addr, last_acc, last_h;
    bit          accept, do_rd, do_wr;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        pio_write_valid   = 1'b0;
        pio_read_valid    = 1'b0;
        pio_address       = '0;
        pio_write_data    = '0;
        rid_tag           = '0;
        completion_valid  = 1'b0;
        irq               = '0;
        ext_read_data     = '0;
        cfg_interrupt_rdy = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [63:0] v);
        pio_write_valid = 1'b1;
        pio_address     = ADDR_W'(a);
        pio_write_data  = v;
        cyc();
        pio_write_valid = 1'b0;
    endtask

    task automatic do_read(input string name, input int a, input logic [3:0] irqv,
                           input logic [63:0] exp);
        logic [23:0] tg;
        tg             = 24'($urandom);
        pio_read_valid = 1'b1;
        pio_address    = ADDR_W'(a);
        rid_tag        = tg;
        irq            = irqv;
        cyc();
        pio_read_valid = 1'b0;
        irq            = '0;
        cyc();
        check64({name, "_valid"}, 64'(read_completion_valid), 64'd1);
        check64({name, "_tag"}, 64'(read_completion_rid_tag), 64'(tg));
        check64({name, "_laddr"}, 64'(read_completion_lower_addr), 64'(a % 16));
        check64({name, "_data"}, read_completion_data, exp);
    endtask

    function automatic logic [63:0] ext_fn(input int c);
        return {32'(c) ^ 32'h5A5A_0000, 32'hFFFF_0000 + 32'(c)};
    endfunction

    function automatic logic [63:0] model_read(input int a);
        case (a)
            0: return VER_WORD | 64'(m_latch);
            1: return 64'(m_latch & m_en);
            2: return (64'(m_cc) << 32) | (64'(m_cw) << 16) | 64'(m_cr);
            3: return 64'(m_msi);
            4: return 64'(m_hold);
            default: return 64'd0;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2, 0,  64'd0,            4'h0, VER_WORD};
        vecs[1]  = '{1, 0,  64'h5,            4'h0, 64'd0};
        vecs[2]  = '{0, 0,  64'd0,            4'h2, 64'd0};
        vecs[3]  = '{2, 1,  64'd0,            4'h0, 64'd0};
        vecs[4]  = '{2, 0,  64'd0,            4'h0, VER_WORD | 64'h2};
        vecs[5]  = '{2, 0,  64'd0,            4'h0, VER_WORD};
        vecs[6]  = '{0, 0,  64'd0,            4'hF, 64'd0};
        vecs[7]  = '{1, 1,  64'h5,            4'h0, 64'd0};
        vecs[8]  = '{2, 1,  64'd0,            4'h0, 64'd0};
        vecs[9]  = '{2, 0,  64'd0,            4'h0, VER_WORD | 64'hA};
        vecs[10] = '{1, 4,  64'h1234_ABCD,    4'h0, 64'd0};
        vecs[11] = '{2, 4,  64'd0,            4'h0, 64'hABCD};
        vecs[12] = '{2, 5,  64'd0,            4'h0, 64'd0};
        vecs[13] = '{1, 3,  64'hFFFF,         4'h0, 64'd0};
        vecs[14] = '{2, 4,  64'd0,            4'h0, 64'hABCD};
        vecs[15] = '{2, 3,  64'd0,            4'h0, 64'd0};
        vecs[16] = '{2, 15, 64'd0,            4'h0, 64'd0};
        vecs[17] = '{1, 0,  64'hF,            4'h0, 64'd0};
        vecs[18] = '{0, 0,  64'd0,            4'h4, 64'd0};
        vecs[19] = '{2, 1,  64'd0,            4'h0, 64'h4};

        reset = 1'b1;
        do_reset();
        check64("rst_cfg_int", 64'(cfg_interrupt), 64'd0);
        check64("rst_rc_valid", 64'(read_completion_valid), 64'd0);
        check64("rst_rc_data", read_completion_data, 64'd0);

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].kind == 0) begin
                irq = vecs[i].irqv;
                cyc();
                irq = '0;
            end else if (vecs[i].kind == 1) begin
                do_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].irqv, vecs[i].exp);
            end
        end

        // Disabled source latches silently; enabled source raises MSI until rdy.
        do_reset();
        do_write(0, 64'h5);
        irq = 4'b0010;
        cyc();
        irq = '0;
        for (int k = 0; k < 3; k++) begin
            check64("msi_disabled_quiet", 64'(cfg_interrupt), 64'd0);
            cyc();
        end
        do_read("latch_disabled", 0, 4'h0, VER_WORD | 64'h2);
        irq = 4'b0100;
        cyc();
        irq = '0;
        check64("msi_rise", 64'(cfg_interrupt), 64'd1);
        cyc();
        cyc();
        check64("msi_hold", 64'(cfg_interrupt), 64'd1);
        cfg_interrupt_rdy = 1'b1;
        cyc();
        cfg_interrupt_rdy = 1'b0;
        check64("msi_drop", 64'(cfg_interrupt), 64'd0);
        do_read("msi_count1", 3, 4'h0, 64'd1);

        // Reset drops an MSI in flight.
        irq = 4'b0001;
        cyc();
        irq = '0;
        check64("msi_pre_reset", 64'(cfg_interrupt), 64'd1);
        do_reset();
        check64("msi_reset_drop", 64'(cfg_interrupt), 64'd0);

        // Holdoff coalescing: three triggers during holdoff give one more MSI.
        do_write(0, 64'h1);
        do_write(4, 64'd10);
        irq = 4'b0001;
        cyc();
        irq = '0;
        acc.delete();
        for (int k = 0; k < 60; k++) begin
            cfg_interrupt_rdy = cfg_interrupt;
            if (cfg_interrupt) acc.push_back(k);
            irq = (k == 1 || k == 3 || k == 5) ? 4'b0001 : 4'b0000;
            cyc();
        end
        cfg_interrupt_rdy = 1'b0;
        irq               = '0;
        check64("holdoff_msi_count", 64'(acc.size()), 64'd2);
        if (acc.size() == 2) check64("holdoff_spacing", 64'(acc[1] - acc[0]), 64'd11);
        do_read("holdoff_msi_reg", 3, 4'h0, 64'd2);

        // holdoff=0: trigger coincident with rdy re-requests immediately.
        do_reset();
        do_write(0, 64'h1);
        irq = 4'b0001;
        cyc();
        check64("b2b_req", 64'(cfg_interrupt), 64'd1);
        cfg_interrupt_rdy = 1'b1;
        cyc();
        irq = '0;
        check64("b2b_rereq", 64'(cfg_interrupt), 64'd1);
        cyc();
        cfg_interrupt_rdy = 1'b0;
        check64("b2b_done", 64'(cfg_interrupt), 64'd0);
        do_read("b2b_msi_reg", 3, 4'h0, 64'd2);

        // Read-clear racing a new irq keeps the new event.
        do_reset();
        do_write(0, 64'hF);
        irq = 4'b0011;
        cyc();
        irq = '0;
        do_read("race_rd0", 0, 4'b1000, VER_WORD | 64'h3);
        do_read("race_rd1", 1, 4'b0000, 64'h8);

        // Traffic counters and clear-wins-over-increment.
        do_reset();
        for (int k = 0; k < 5; k++) do_write(7, {$urandom, $urandom});
        for (int k = 0; k < 3; k++) do_read("cnt_dummy", 5, 4'h0, 64'd0);
        completion_valid = 1'b1;
        cyc();
        cyc();
        completion_valid = 1'b0;
        do_read("cnt_values", 2, 4'h0, 64'h0000_0002_0005_0003);
        completion_valid = 1'b1;
        do_write(2, 64'd0);
        completion_valid = 1'b0;
        do_read("cnt_cleared", 2, 4'h0, 64'd0);

        // Back-to-back external reads, then reset mid-stream.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            pio_read_valid = (i < 4);
            pio_address    = ADDR_W'(16 + i);
            rid_tag        = 24'hA0_0000 + 24'(i);
            ext_read_data  = (i >= 1 && i <= 4) ? 64'((16 + i - 1) * 3) : 64'hDEAD_BEEF;
            if (i >= 2 && i <= 5) begin
                check64("ext_valid", 64'(read_completion_valid), 64'd1);
                check64("ext_data", read_completion_data, 64'((16 + i - 2) * 3));
                check64("ext_tag", 64'(read_completion_rid_tag), 64'(24'hA0_0000 + 24'(i - 2)));
                check64("ext_laddr", 64'(read_completion_lower_addr), 64'(i - 2));
            end else if (i == 6) begin
                check64("ext_tail_idle", 64'(read_completion_valid), 64'd0);
            end
            cyc();
        end
        for (int i = 0; i < 10; i++) begin
            pio_read_valid = (i < 4);
            pio_address    = ADDR_W'(16 + i);
            rid_tag        = 24'hB0_0000 + 24'(i);
            ext_read_data  = 64'hCAFE;
            reset          = (i == 3);
            if (i >= 4) check64("post_reset_quiet", 64'(read_completion_valid), 64'd0);
            cyc();
        end
        idle();
        reset = 1'b0;

        // Randomized traffic against the behavioural model.
        do_reset();
        m_latch  = '0;
        m_en     = '0;
        m_hold   = 0;
        m_cr     = 0;
        m_cw     = 0;
        m_cc     = 0;
        m_msi    = '0;
        last_acc = -1;
        last_h   = 0;
        expq.delete();
        for (int c = 0; c < N_RAND + 4; c++) begin
            if (expq.size() > 0 && expq[0].due == c) begin
                e = expq.pop_front();
                check64("rnd_valid", 64'(read_completion_valid), 64'd1);
                check64("rnd_data", read_completion_data, e.data);
                check64("rnd_tag", 64'(read_completion_rid_tag), 64'(e.tag));
                check64("rnd_laddr", 64'(read_completion_lower_addr), 64'(e.la));
            end else begin
                check64("rnd_idle", 64'(read_completion_valid), 64'd0);
            end
            idle();
            if (c < N_RAND) begin
                cfg_interrupt_rdy = ($urandom_range(0, 2) == 0);
                accept = cfg_interrupt && cfg_interrupt_rdy;
                if (accept) begin
                    if (last_acc >= 0) begin
                        n_checks++;
                        if (c - last_acc < last_h + 1) begin
                            n_fail++;
                            $display("FAIL rnd_msi_spacing: got %0d cycles, required >= %0d",
                                     c - last_acc, last_h + 1);
                        end
                    end
                    last_acc = c;
                    last_h   = int'(m_hold);
                end
                irq              = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
                completion_valid = ($urandom_range(0, 3) == 0);
                ext_read_data    = ext_fn(c);
                rtag             = 24'($urandom);
                rid_tag          = rtag;
                op               = $urandom_range(0, 9);
                do_rd            = (op <= 3);
                do_wr            = (op >= 4 && op <= 6);
                addr             = 0;
                wdata            = {$urandom, $urandom};
                if (do_rd) begin
                    sel  = $urandom_range(0, 7);
                    addr = (sel <= 5) ? sel : ((sel == 6) ? 9 : 16 + $urandom_range(0, 100));
                    pio_read_valid = 1'b1;
                    pio_address    = ADDR_W'(addr);
                    expq.push_back('{c + 2, rtag, 4'(addr),
                                     (addr >= 16) ? ext_fn(c + 1) : model_read(addr)});
                end else if (do_wr) begin
                    sel  = $urandom_range(0, 7);
                    addr = (sel == 0 || sel == 7) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 2 :
                           (sel <= 4) ? 4 : (sel == 5) ? 6 : 20;
                    if (addr == 4) wdata[15:0] = 16'($urandom_range(0, 6));
                    pio_write_valid = 1'b1;
                    pio_address     = ADDR_W'(addr);
                    pio_write_data  = wdata;
                end
                clr = 4'h0;
                if (do_rd && addr == 0) clr = 4'hF;
                if (do_wr && addr == 1) clr = wdata[3:0];
                m_latch = (m_latch & ~clr) | irq;
                if (do_wr && addr == 0) m_en = wdata[3:0];
                if (do_wr && addr == 4) m_hold = int'(wdata[15:0]);
                if (do_wr && addr == 2) begin
                    m_cr = 0;
                    m_cw = 0;
                    m_cc = 0;
                end else begin
                    if (do_rd) m_cr = (m_cr + 1) % (1 << COUNT_W);
                    if (do_wr) m_cw = (m_cw + 1) % (1 << COUNT_W);
                    if (completion_valid) m_cc = (m_cc + 1) % (1 << COUNT_W);
                end
                if (accept) m_msi = m_msi + 32'd1;
            end
            cyc();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
